// File: rtl/std_pipe_pkg.sv
// std_pipe_pkg -- shared helpers for the std_pipe_reg pipeline slice.
//   cnt_width(depth) : bit width needed to hold an item count of 0..depth.
package std_pipe_pkg;

  function automatic int cnt_width(input int depth);
    // Clamp so an illegal DEPTH still yields a legal port width; the top
    // module reports the real error at elaboration.
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/std_pipe_stage.sv
// std_pipe_stage -- one register stage of the std_pipe_reg pipeline.
// Ports:
//   clk, reset   : clock, synchronous active-high reset
//   flush        : clear valid at the next edge, keep data
//   ready        : this stage may take from upstream this cycle
//   prev_valid   : upstream stage (or input handshake) holds an item
//   prev_data    : upstream payload
//   valid, data  : registered stage state
module std_pipe_stage #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             ready,
  input  logic             prev_valid,
  input  logic [WIDTH-1:0] prev_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= RESET_VAL;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= prev_valid;
      // Holding data on an empty upstream keeps the datapath quiet.
      if (prev_valid) begin
        data <= prev_data;
      end
    end
  end

endmodule

// File: rtl/std_pipe_reg.sv
// std_pipe_reg -- valid/ready pipeline register chain with bubble collapse.
// Ports:
//   clk, reset            : clock, synchronous active-high reset
//   in_data/in_valid      : upstream payload and offer
//   in_ready              : upstream transfer accepted this cycle
//   out_data/out_valid    : final-stage payload and valid
//   out_ready             : downstream accepts this cycle
//   flush                 : discard every held item
//   count                 : number of valid stages
// Parameters: WIDTH data bits, DEPTH stages (>= 1), RESET_VAL stage data on reset.
module std_pipe_reg
  import std_pipe_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  input  logic                         flush,
  output logic [cnt_width(DEPTH)-1:0]  count
);

  localparam int CW = cnt_width(DEPTH);

  if (DEPTH < 1) begin : g_bad_depth
    $error("std_pipe_reg: DEPTH must be >= 1");
  end
  if (WIDTH < 1) begin : g_bad_width
    $error("std_pipe_reg: WIDTH must be >= 1");
  end

  logic [DEPTH-1:0] valid;
  logic [DEPTH:0]   ready;
  logic [DEPTH-1:0] src_valid;
  logic [WIDTH-1:0] data     [DEPTH];
  logic [WIDTH-1:0] src_data [DEPTH];
  logic             in_fire;

  // ready[i] ripples back from out_ready so a stalled tail still lets
  // empty stages further up fill in.
  always_comb begin
    ready        = '0;
    ready[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      ready[i] = !valid[i] || ready[i+1];
    end
  end

  assign in_ready = ready[0] && !flush;
  assign in_fire  = in_valid && in_ready;

  always_comb begin
    src_valid[0] = in_fire;
    src_data[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      src_valid[i] = valid[i-1];
      src_data[i]  = data[i-1];
    end
  end

  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    std_pipe_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .ready      (ready[g]),
      .prev_valid (src_valid[g]),
      .prev_data  (src_data[g]),
      .valid      (valid[g]),
      .data       (data[g])
    );
  end

  // The output valid is masked during flush so no transfer can complete
  // in a flush cycle.
  assign out_valid = valid[DEPTH-1] && !flush;
  assign out_data  = data[DEPTH-1];

  always_comb begin
    count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count = count + CW'(valid[i]);
    end
  end

endmodule

// File: tb/tb_std_pipe_reg.sv
module tb_std_pipe_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;

  logic [7:0] a_in_data;
  logic       a_in_valid;
  logic       a_in_ready;
  logic [7:0] a_out_data;
  logic       a_out_valid;
  logic       a_out_ready;
  logic       a_flush;
  logic [1:0] a_count;

  logic [7:0] b_in_data;
  logic       b_in_valid;
  logic       b_in_ready;
  logic [7:0] b_out_data;
  logic       b_out_valid;
  logic       b_out_ready;
  logic       b_flush;
  logic [0:0] b_count;

  int total  = 0;
  int passed = 0;

  std_pipe_reg #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) u_dut_a (
    .clk       (clk),
    .reset     (reset),
    .in_data   (a_in_data),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .flush     (a_flush),
    .count     (a_count)
  );

  std_pipe_reg #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h00)) u_dut_b (
    .clk       (clk),
    .reset     (reset),
    .in_data   (b_in_data),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .flush     (b_flush),
    .count     (b_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  initial begin
    reset       = 1'b1;
    a_in_data   = 8'h00;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    a_flush     = 1'b0;
    b_in_data   = 8'h00;
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    b_flush     = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    check("rst_count",     32'(a_count),     0);
    check("rst_out_valid", 32'(a_out_valid), 0);
    check("rst_out_data",  32'(a_out_data),  0);
    check("rst_in_ready",  32'(a_in_ready),  1);
    check("rst_b_count",   32'(b_count),     0);

    // Streaming 0x01..0x05 with out_ready high
    for (int k = 0; k < 7; k++) begin
      a_in_valid = (k < 5);
      a_in_data  = 8'(k + 1);
      tick();
      if (k >= 2) begin
        check("stream_valid", 32'(a_out_valid), 1);
        check("stream_data",  32'(a_out_data),  32'(k - 1));
      end else begin
        check("stream_latency", 32'(a_out_valid), 0);
      end
      check("stream_count", 32'(a_count), (k < 5) ? ((k + 1 < 3) ? k + 1 : 3) : 7 - k);
    end
    a_in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(a_count), 0);

    // Backpressure: 0x11..0x14 with out_ready low
    a_out_ready = 1'b0;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h11; tick();
    a_in_data   = 8'h12; tick();
    a_in_data   = 8'h13; tick();
    check("full_count", 32'(a_count),    3);
    check("full_data",  32'(a_out_data), 32'h11);
    a_in_data = 8'h14;
    #1;
    check("full_in_ready", 32'(a_in_ready), 0);
    tick();
    check("stall_count",    32'(a_count),    3);
    check("stall_in_ready", 32'(a_in_ready), 0);
    check("stall_data",     32'(a_out_data), 32'h11);
    a_out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(a_in_ready), 1);
    tick();
    check("release_data",  32'(a_out_data), 32'h12);
    check("release_count", 32'(a_count),    3);
    a_in_valid = 1'b0;
    tick();
    check("release_data13", 32'(a_out_data), 32'h13);
    tick();
    check("release_data14",  32'(a_out_data),  32'h14);
    check("release_valid14", 32'(a_out_valid), 1);
    tick();
    check("release_empty", 32'(a_out_valid), 0);

    // Bubble collapse: A0, idle, A1 with out_ready low
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'hA0; tick();
    a_in_valid = 1'b0;                    tick();
    a_in_valid = 1'b1; a_in_data = 8'hA1; tick();
    a_in_valid = 1'b0;                    tick();
    check("bubble_count",    32'(a_count),    2);
    check("bubble_data",     32'(a_out_data), 32'hA0);
    check("bubble_in_ready", 32'(a_in_ready), 1);
    a_out_ready = 1'b1;
    tick();
    check("bubble_next_data",  32'(a_out_data),  32'hA1);
    check("bubble_next_valid", 32'(a_out_valid), 1);
    check("bubble_next_count", 32'(a_count),     1);
    tick();
    check("bubble_empty", 32'(a_count), 0);

    // Flush with two held items and a competing input
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h31; tick();
    a_in_data  = 8'h32;                   tick();
    a_in_valid = 1'b0;                    tick();
    check("preflush_count", 32'(a_count),     2);
    check("preflush_valid", 32'(a_out_valid), 1);
    a_flush     = 1'b1;
    a_in_valid  = 1'b1;
    a_in_data   = 8'h55;
    a_out_ready = 1'b1;
    #1;
    check("flush_out_valid", 32'(a_out_valid), 0);
    check("flush_in_ready",  32'(a_in_ready),  0);
    tick();
    a_flush    = 1'b0;
    a_in_valid = 1'b0;
    #1;
    check("postflush_count", 32'(a_count),     0);
    check("postflush_valid", 32'(a_out_valid), 0);
    check("postflush_data",  32'(a_out_data),  32'h31);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("flush_no_55", 32'(a_out_valid), 0);
    end

    // Mid-stream reset with three held items
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 8'h21; tick();
    a_in_data  = 8'h22;                   tick();
    a_in_data  = 8'h23;                   tick();
    check("prereset_count", 32'(a_count), 3);
    reset       = 1'b1;
    a_in_data   = 8'h99;
    a_out_ready = 1'b1;
    tick();
    reset      = 1'b0;
    a_in_valid = 1'b0;
    #1;
    check("midrst_count",    32'(a_count),     0);
    check("midrst_valid",    32'(a_out_valid), 0);
    check("midrst_data",     32'(a_out_data),  0);
    check("midrst_in_ready", 32'(a_in_ready),  1);
    tick();
    check("midrst_no_99", 32'(a_out_valid), 0);

    // DEPTH=1 back-to-back
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = 8'h7E; tick();
    check("d1_valid_7e",  32'(b_out_valid), 1);
    check("d1_data_7e",   32'(b_out_data),  32'h7E);
    check("d1_in_ready",  32'(b_in_ready),  1);
    check("d1_count",     32'(b_count),     1);
    b_in_data = 8'h7F; tick();
    check("d1_valid_7f", 32'(b_out_valid), 1);
    check("d1_data_7f",  32'(b_out_data),  32'h7F);
    b_in_valid = 1'b0; tick();
    check("d1_empty", 32'(b_out_valid), 0);
    b_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 8'h3C; tick();
    check("d1_full_in_ready", 32'(b_in_ready), 0);
    b_in_data = 8'h3D; tick();
    check("d1_hold_data", 32'(b_out_data), 32'h3C);
    check("d1_hold_count", 32'(b_count),   1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
